univ_sseg_driver: RTL and testbench
===================================

Name: univ_sseg_driver

Overview:
- Universal 4-digit, 7-segment display driver for the board's common-anode display.
- Formats one or two binary counts (hex, decimal, split decimal or signed decimal) and time-multiplexes the four digits.
- Drives active-low segment cathodes and active-low digit anodes.
- Sits at top level and displays counter/measurement results, e.g. the ring-oscillator count.

Parameters:
- REFRESH_BITS, 17, width of the free-running prescaler; digit advances every 2^REFRESH_BITS clk cycles (≈1.3 ms at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cnt1  input  14  primary unsigned value.
- cnt2  input  7  secondary unsigned value (mode 01 only).
- valid  input  1  1 = show data; 0 = all digits blank.
- dp_en  input  1  enable decimal point.
- dp_sel  input  2  digit index (0 = rightmost) carrying the decimal point.
- mod_sel  input  2  display mode, see Behaviour.
- sign  input  1  minus flag for mode 11.
- ssegs  output  8  active-low cathodes: [0]=a … [6]=g, [7]=dp.
- disp_en  output  4  active-low anodes: [0]=rightmost digit … [3]=leftmost.

Behaviour:
- Reset (async, rst_n=0): prescaler=0, digit index=0, ssegs=8'hFF, disp_en=4'b1111. These values hold while rst_n is low.
- Prescaler: free-running REFRESH_BITS-bit counter. A tick occurs on the cycle it equals all-ones, then it wraps to 0.
- Digit index: 2-bit, increments on each tick, wraps 3→0.
- Outputs are registered every clk from the current index and current inputs, giving 1-cycle latency to input changes.
- disp_en: exactly one bit low (bit = index) whenever out of reset.
- Mode 00, hex: digits 3..0 = nibbles of {2'b00, cnt1}. Always in range.
- Mode 01, split decimal: digits 3..2 = cnt2 in decimal (00–99); digits 1..0 = cnt1 in decimal (00–99).
  - cnt2 > 99: digits 3..2 show dash.
  - cnt1 > 99: digits 1..0 show dash.
  - Leading zeros are shown.
- Mode 10, decimal: digits 3..0 = cnt1 in decimal, 0–9999.
  - Leading zeros are blanked; digit 0 always shown, so value 0 shows "   0".
  - cnt1 > 9999: all four digits show dash.
- Mode 11, signed: digit 3 = dash if sign=1, blank if sign=0. Digits 2..0 = cnt1 in decimal, 0–999, leading zeros blanked (digit 0 always shown).
  - cnt1 > 999: digits 2..0 show dash, digit 3 still follows sign.
- Glyphs: 0–9 and A–F use standard shapes (b, d lowercase). Dash = only g low (ssegs=8'hBF). Blank = 7'h7F on [6:0].
- Decimal point: ssegs[7]=0 only when dp_en=1 and valid=1 and index==dp_sel; otherwise 1.
- valid=0: disp_en keeps scanning; ssegs=8'hFF on every digit.
- Binary-to-BCD conversion is combinational or pipelined internally, but the 1-cycle input-to-output latency is mandatory.
- Input changes between ticks take effect on the next clk for the currently lit digit. No glitch beyond one cycle.
- rst_n asserted mid-scan forces reset values immediately. After release, scanning restarts at digit 0 with a full prescaler period.

Test Plan:
- Reset/scan (REFRESH_BITS=2): assert rst_n=0 → ssegs=8'hFF, disp_en=4'b1111. Release → disp_en cycles 1110, 1101, 1011, 0111, 1110, each held 4 clks.
- Mode 10, cnt1=1234, valid=1, dp_en=0 → per-digit ssegs = '4','3','2','1' (digit0='4' = 8'h99). Then cnt1=7 → digits 3..1 blank (8'hFF), digit0='7'. Then cnt1=10000 → all four digits show dash 8'hBF.
- Mode 00, cnt1=14'h3A5F → digits 3..0 = '3','A','5','F'. Mode 01, cnt2=42, cnt1=105 → digits 3..2 = '4','2'; digits 1..0 = dash.
- Mode 11, sign=1, cnt1=56 → digit3 = dash, digit2 blank, digits 1..0 = '5','6'. Then sign=0 → digit3 blank.
- Decimal point: dp_en=1, dp_sel=2, mode 10, cnt1=9999 → ssegs[7]=0 only while disp_en=4'b1011; then valid=0 → ssegs=8'hFF on all digits.
- Async reset while digit 2 is active → outputs go to reset values before the next clk edge. After release, first active digit is digit 0.

Source files
------------

// File: rtl/univ_sseg_driver.sv
// Universal 4-digit common-anode 7-segment driver: hex, split decimal,
// decimal and signed decimal formats, time-multiplexed, active-low outputs.
module univ_sseg_driver #(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] cnt1,
  input  logic [6:0]  cnt2,
  input  logic        valid,
  input  logic        dp_en,
  input  logic [1:0]  dp_sel,
  input  logic [1:0]  mod_sel,
  input  logic        sign,
  output logic [7:0]  ssegs,
  output logic [3:0]  disp_en
);

  localparam int unsigned BIN_W   = 14;
  localparam int unsigned BCD_W   = 20;
  localparam int unsigned SYM_W   = 5;
  localparam int unsigned NDIGITS = 4;

  // Display modes
  localparam logic [1:0] MODE_HEX    = 2'b00;
  localparam logic [1:0] MODE_SPLIT  = 2'b01;
  localparam logic [1:0] MODE_DEC    = 2'b10;
  localparam logic [1:0] MODE_SIGNED = 2'b11;

  // Symbols beyond the 16 hex glyphs
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'd16;
  localparam logic [SYM_W-1:0] SYM_BLANK = 5'd17;

  logic [REFRESH_BITS-1:0] presc;
  logic [1:0]              idx;
  logic                    tick_c;

  logic [BCD_W-1:0]              bcd1_c;
  logic [BCD_W-1:0]              bcd2_c;
  logic [NDIGITS-1:0][SYM_W-1:0] sym_c;
  logic [SYM_W-1:0]              cur_sym_c;
  logic [6:0]                    seg_c;
  logic                          dp_on_c;

  // Shift-and-add-3 binary to 5-digit BCD conversion
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [BIN_W-1:0] bin);
    logic [BCD_W-1:0] bcd;
    bcd = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BCD_W-2:0], bin[i]};
    end
    return bcd;
  endfunction

  // Symbol to active-low segment pattern, bit order g..a
  function automatic logic [6:0] glyph(input logic [SYM_W-1:0] sym);
    logic [6:0] seg;
    case (sym)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = 7'h06;
      5'd15:   seg = 7'h0E;
      SYM_DASH: seg = 7'h3F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign tick_c = &presc;

  // Free-running prescaler and digit scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + REFRESH_BITS'(1);
      if (tick_c) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // BCD digits for both inputs
  always_comb begin
    bcd1_c = bin2bcd(cnt1);
    bcd2_c = bin2bcd(BIN_W'(cnt2));
  end

  // Per-digit symbol selection for the active mode
  always_comb begin
    sym_c = {NDIGITS{SYM_BLANK}};
    case (mod_sel)
      MODE_HEX: begin
        sym_c[3] = {1'b0, 2'b00, cnt1[13:12]};
        sym_c[2] = {1'b0, cnt1[11:8]};
        sym_c[1] = {1'b0, cnt1[7:4]};
        sym_c[0] = {1'b0, cnt1[3:0]};
      end
      MODE_SPLIT: begin
        if (cnt2 > 7'd99) begin
          sym_c[3] = SYM_DASH;
          sym_c[2] = SYM_DASH;
        end else begin
          sym_c[3] = {1'b0, bcd2_c[7:4]};
          sym_c[2] = {1'b0, bcd2_c[3:0]};
        end
        if (cnt1 > 14'd99) begin
          sym_c[1] = SYM_DASH;
          sym_c[0] = SYM_DASH;
        end else begin
          sym_c[1] = {1'b0, bcd1_c[7:4]};
          sym_c[0] = {1'b0, bcd1_c[3:0]};
        end
      end
      MODE_DEC: begin
        if (cnt1 > 14'd9999) begin
          sym_c = {NDIGITS{SYM_DASH}};
        end else begin
          sym_c[0] = {1'b0, bcd1_c[3:0]};
          if (bcd1_c[15:4] != 12'd0) sym_c[1] = {1'b0, bcd1_c[7:4]};
          if (bcd1_c[15:8] != 8'd0)  sym_c[2] = {1'b0, bcd1_c[11:8]};
          if (bcd1_c[15:12] != 4'd0) sym_c[3] = {1'b0, bcd1_c[15:12]};
        end
      end
      MODE_SIGNED: begin
        sym_c[3] = sign ? SYM_DASH : SYM_BLANK;
        if (cnt1 > 14'd999) begin
          sym_c[2] = SYM_DASH;
          sym_c[1] = SYM_DASH;
          sym_c[0] = SYM_DASH;
        end else begin
          sym_c[0] = {1'b0, bcd1_c[3:0]};
          if (bcd1_c[11:4] != 8'd0) sym_c[1] = {1'b0, bcd1_c[7:4]};
          if (bcd1_c[11:8] != 4'd0) sym_c[2] = {1'b0, bcd1_c[11:8]};
        end
      end
      default: sym_c = {NDIGITS{SYM_BLANK}};
    endcase
  end

  // Glyph and decimal point for the currently lit digit
  always_comb begin
    cur_sym_c = sym_c[idx];
    seg_c     = glyph(cur_sym_c);
    dp_on_c   = dp_en && valid && (idx == dp_sel);
  end

  // Registered cathode and anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssegs   <= 8'hFF;
      disp_en <= 4'b1111;
    end else begin
      disp_en <= ~(4'b0001 << idx);
      ssegs   <= valid ? {~dp_on_c, seg_c} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_univ_sseg_driver.sv
// Directed bench for univ_sseg_driver with a short refresh period.
module tb_univ_sseg_driver;

  logic        clk;
  logic        rst_n;
  logic [13:0] cnt1;
  logic [6:0]  cnt2;
  logic        valid;
  logic        dp_en;
  logic [1:0]  dp_sel;
  logic [1:0]  mod_sel;
  logic        sign;
  logic [7:0]  ssegs;
  logic [3:0]  disp_en;

  int n_checks = 0;
  int n_fails  = 0;

  univ_sseg_driver #(.REFRESH_BITS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .valid   (valid),
    .dp_en   (dp_en),
    .dp_sel  (dp_sel),
    .mod_sel (mod_sel),
    .sign    (sign),
    .ssegs   (ssegs),
    .disp_en (disp_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge where digit d is lit; bounded wait
  task automatic wait_lit(input string tag, input int d);
    logic [3:0] target;
    bit         found;
    target = ~(4'b0001 << d);
    found  = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (disp_en == target) found = 1'b1;
    end
    if (!found) check_eq({tag, "_scan_timeout"}, 32'(disp_en), 32'(target));
  endtask

  // Visit each digit 0..3 and compare its cathode pattern
  task automatic check_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int d = 0; d < 4; d++) begin
      wait_lit(tag, d);
      check_eq($sformatf("%s_d%0d", tag, d), 32'(ssegs), 32'(exp[d]));
    end
  endtask

  initial begin
    logic [3:0] exp_en;
    rst_n   = 1'b0;
    cnt1    = '0;
    cnt2    = '0;
    valid   = 1'b1;
    dp_en   = 1'b0;
    dp_sel  = 2'd0;
    mod_sel = 2'b10;
    sign    = 1'b0;

    // Reset values held while rst_n low
    repeat (3) @(negedge clk);
    check_eq("rst_ssegs", 32'(ssegs), 32'h0FF);
    check_eq("rst_disp_en", 32'(disp_en), 32'hF);

    // Scan order, four clocks per digit
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_en = ~(4'b0001 << (((k - 1) / 4) % 4));
      check_eq($sformatf("scan_k%0d", k), 32'(disp_en), 32'(exp_en));
    end

    // Mode 10 decimal
    mod_sel = 2'b10; cnt1 = 14'd1234;
    check_digits("dec1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    cnt1 = 14'd7;
    check_digits("dec7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    cnt1 = 14'd0;
    check_digits("dec0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    cnt1 = 14'd10000;
    check_digits("dec_ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    // Mode 00 hex
    mod_sel = 2'b00; cnt1 = 14'h3A5F;
    check_digits("hex", 8'hB0, 8'h88, 8'h92, 8'h8E);

    // Mode 01 split decimal
    mod_sel = 2'b01; cnt2 = 7'd42; cnt1 = 14'd105;
    check_digits("split_a", 8'h99, 8'hA4, 8'hBF, 8'hBF);
    cnt2 = 7'd100; cnt1 = 14'd7;
    check_digits("split_b", 8'hBF, 8'hBF, 8'hC0, 8'hF8);

    // Mode 11 signed
    mod_sel = 2'b11; sign = 1'b1; cnt1 = 14'd56;
    check_digits("sgn_neg", 8'hBF, 8'hFF, 8'h92, 8'h82);
    sign = 1'b0;
    check_digits("sgn_pos", 8'hFF, 8'hFF, 8'h92, 8'h82);
    sign = 1'b1; cnt1 = 14'd1000;
    check_digits("sgn_ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    // Decimal point on digit 2
    mod_sel = 2'b10; sign = 1'b0; cnt1 = 14'd9999; dp_en = 1'b1; dp_sel = 2'd2;
    check_digits("dp", 8'h90, 8'h10, 8'h90, 8'h90);
    valid = 1'b0;
    check_digits("invalid", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Async reset mid-scan while digit 2 lit
    valid = 1'b1; dp_en = 1'b0; cnt1 = 14'd1234;
    wait_lit("arst", 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_ssegs", 32'(ssegs), 32'h0FF);
    check_eq("arst_disp_en", 32'(disp_en), 32'hF);
    repeat (2) @(negedge clk);
    check_eq("arst_hold", 32'(disp_en), 32'hF);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_en = (k <= 4) ? 4'b1110 : 4'b1101;
      check_eq($sformatf("arst_scan_k%0d", k), 32'(disp_en), 32'(exp_en));
    end
    check_eq("arst_first_digit", 32'(ssegs), 32'h0B0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
